// File: rtl/muxer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muxer_pkg
// Description : Shared constants, state encoding and saturation helper for
//               the bumpless N:1 signal selector.
// Revision    : 1.0 - initial release
// ============================================================================
package muxer_pkg;

    // Transition modes applied when the selected source changes
    localparam logic [1:0] MODE_DIRECT = 2'd0;
    localparam logic [1:0] MODE_HOLD   = 2'd1;
    localparam logic [1:0] MODE_RAMP   = 2'd2;

    // Selector state encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_RAMP = 2'd2
    } state_t;

    // Clamp a sign-extended value into the signed range of a res-bit sample
    function automatic logic signed [31:0] sat_res(input logic signed [31:0] value,
                                                   input int                 res);
        logic signed [31:0] c_hi;
        logic signed [31:0] c_lo;
        c_hi = (32'sd1 <<< (res - 1)) - 32'sd1;
        c_lo = -(32'sd1 <<< (res - 1));
        if (value > c_hi)
            return c_hi;
        else if (value < c_lo)
            return c_lo;
        else
            return value;
    endfunction

endpackage
`default_nettype wire

// File: rtl/muxer_ramp_step.sv
`default_nettype none
// ============================================================================
// Module      : muxer_ramp_step
// Description : Moves a signed ramp offset one step toward zero. A zero step
//               is promoted to one so a ramp always terminates.
// Revision    : 1.0 - initial release
// ============================================================================
module muxer_ramp_step #(
    parameter int RES = 14
) (
    input  logic signed [RES:0]   i_offset,
    input  logic        [RES-2:0] i_step,
    output logic signed [RES:0]   o_off_n,
    output logic                  o_done
);
    import muxer_pkg::*;

    logic        [RES-1:0] w_step_eff;
    logic        [RES:0]   w_mag;
    logic signed [RES:0]   w_step_s;

    // Magnitude of the offset and effective step; done when one step reaches zero
    always_comb begin
        w_step_eff = (i_step == '0) ? RES'(1) : {1'b0, i_step};
        w_step_s   = $signed({1'b0, w_step_eff});
        // Unsigned magnitude; the RES+1-bit width keeps the most negative value exact
        w_mag      = i_offset[RES] ? (~i_offset + 1'b1) : i_offset;
        o_done     = (w_mag <= {1'b0, w_step_eff});
        if (o_done)
            o_off_n = '0;
        else if (i_offset[RES])
            o_off_n = i_offset + w_step_s;
        else
            o_off_n = i_offset - w_step_s;
    end

endmodule
`default_nettype wire

// File: rtl/muxer_bumpless.sv
`default_nettype none
// ============================================================================
// Module      : muxer_bumpless
// Description : Registered N:1 signal selector with direct, frozen-hold or
//               bumpless linear-ramp transitions when the selection changes.
// Revision    : 1.0 - initial release
// ============================================================================
module muxer_bumpless #(
    parameter int RES = 14,
    parameter int SW  = 4,
    parameter int HW  = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic        [SW-1:0]       sel,
    input  logic        [(2**SW)*RES-1:0] in_bus,
    input  logic        [1:0]          mode,
    input  logic        [HW-1:0]       hold_len,
    input  logic        [RES-2:0]      step,
    output logic signed [RES-1:0]      out,
    output logic        [SW-1:0]       sel_active,
    output logic                       busy
);
    import muxer_pkg::*;

    localparam int NIN = 2**SW;

    logic signed [RES-1:0] w_in [NIN];

    state_t                r_state;
    logic signed [RES-1:0] r_out;
    logic        [SW-1:0]  r_sel_active;
    logic                  r_busy;
    logic signed [RES:0]   r_offset;
    logic        [HW-1:0]  r_cnt;

    state_t                w_state_n;
    logic signed [RES-1:0] w_out_n;
    logic        [SW-1:0]  w_sel_n;
    logic signed [RES:0]   w_offset_n;
    logic        [HW-1:0]  w_cnt_n;

    logic signed [RES:0]   w_switch_off;
    logic signed [RES:0]   w_ramp_off;
    logic                  w_ramp_done;
    logic signed [RES+1:0] w_sum;
    logic signed [31:0]    w_sat;

    // Unpack the flat input bus into an indexable array
    for (genvar k = 0; k < NIN; k++) begin : g_unpack
        assign w_in[k] = in_bus[k*RES +: RES];
    end

    muxer_ramp_step #(
        .RES      (RES)
    ) u_ramp_step (
        .i_offset (r_offset),
        .i_step   (step),
        .o_off_n  (w_ramp_off),
        .o_done   (w_ramp_done)
    );

    // Offset at switch time, and ramped output with saturation
    always_comb begin
        w_switch_off = $signed({r_out[RES-1], r_out}) - $signed({w_in[sel][RES-1], w_in[sel]});
        w_sum        = $signed({{2{w_in[r_sel_active][RES-1]}}, w_in[r_sel_active]})
                     + $signed({w_ramp_off[RES], w_ramp_off});
        w_sat        = sat_res($signed({{(32-(RES+2)){w_sum[RES+1]}}, w_sum}), RES);
    end

    // Next-state and datapath decisions
    always_comb begin
        w_state_n  = r_state;
        w_out_n    = r_out;
        w_sel_n    = r_sel_active;
        w_offset_n = r_offset;
        w_cnt_n    = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (sel == r_sel_active) begin
                    w_out_n = w_in[r_sel_active];
                end else begin
                    // Switch event: mode is only looked at here
                    w_sel_n = sel;
                    case (mode)
                        MODE_HOLD: begin
                            if (hold_len == '0) begin
                                w_out_n = w_in[sel];
                            end else begin
                                w_cnt_n   = hold_len - HW'(1);
                                w_state_n = ST_HOLD;
                            end
                        end
                        MODE_RAMP: begin
                            w_offset_n = w_switch_off;
                            w_state_n  = ST_RAMP;
                        end
                        default: begin
                            w_out_n = w_in[sel];
                        end
                    endcase
                end
            end
            ST_HOLD: begin
                if (r_cnt == '0)
                    w_state_n = ST_IDLE;
                else
                    w_cnt_n = r_cnt - HW'(1);
            end
            ST_RAMP: begin
                w_out_n    = w_sat[RES-1:0];
                w_offset_n = w_ramp_off;
                if (w_ramp_done)
                    w_state_n = ST_IDLE;
            end
            default: begin
                w_state_n = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_out        <= '0;
            r_sel_active <= '0;
            r_busy       <= 1'b0;
            r_offset     <= '0;
            r_cnt        <= '0;
        end else begin
            r_state      <= w_state_n;
            r_out        <= w_out_n;
            r_sel_active <= w_sel_n;
            r_busy       <= (w_state_n != ST_IDLE);
            r_offset     <= w_offset_n;
            r_cnt        <= w_cnt_n;
        end
    end

    assign out        = r_out;
    assign sel_active = r_sel_active;
    assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_muxer_bumpless.sv
`default_nettype none
// ============================================================================
// Module      : tb_muxer_bumpless
// Description : Scoreboard testbench for muxer_bumpless: directed scenarios
//               followed by randomized traffic against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muxer_bumpless;

    localparam int RES = 14;
    localparam int SW  = 4;
    localparam int HW  = 10;
    localparam int NIN = 2**SW;

    typedef struct {
        int out;
        int sel;
        int busy;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [SW-1:0]         sel = '0;
    logic [1:0]            mode = 2'd0;
    logic [HW-1:0]         hold_len = '0;
    logic [RES-2:0]        step = '0;
    logic signed [RES-1:0] ins [NIN];
    logic [NIN*RES-1:0]    in_bus;
    logic signed [RES-1:0] out;
    logic [SW-1:0]         sel_active;
    logic                  busy;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Model state: what the output is doing, in plain integers
    int m_out = 0;
    int m_sel = 0;
    int frozen_left = 0;
    int ramp_off = 0;
    bit ramping = 1'b0;

    muxer_bumpless #(
        .RES        (RES),
        .SW         (SW),
        .HW         (HW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sel        (sel),
        .in_bus     (in_bus),
        .mode       (mode),
        .hold_len   (hold_len),
        .step       (step),
        .out        (out),
        .sel_active (sel_active),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        in_bus = '0;
        for (int k = 0; k < NIN; k++)
            in_bus[k*RES +: RES] = ins[k];
    end

    function automatic int clamp(input int v);
        if (v > 8191)  return 8191;
        if (v < -8192) return -8192;
        return v;
    endfunction

    // Advance the model by one clock using the inputs as they stand
    task automatic model_step();
        int s;
        int a;
        exp_t e;
        if (rst) begin
            m_out = 0; m_sel = 0; frozen_left = 0; ramp_off = 0; ramping = 1'b0;
        end else if (frozen_left > 0) begin
            frozen_left = frozen_left - 1;
        end else if (ramping) begin
            s = (step == 0) ? 1 : int'(step);
            a = (ramp_off < 0) ? -ramp_off : ramp_off;
            if (a <= s)          ramp_off = 0;
            else if (ramp_off > 0) ramp_off = ramp_off - s;
            else                 ramp_off = ramp_off + s;
            m_out = clamp(int'(ins[m_sel]) + ramp_off);
            if (ramp_off == 0) ramping = 1'b0;
        end else if (int'(sel) == m_sel) begin
            m_out = int'(ins[m_sel]);
        end else begin
            m_sel = int'(sel);
            if (mode == 2'd1 && hold_len != 0) begin
                frozen_left = int'(hold_len);
            end else if (mode == 2'd2) begin
                ramp_off = m_out - int'(ins[m_sel]);
                ramping  = 1'b1;
            end else begin
                m_out = int'(ins[m_sel]);
            end
        end
        e.out  = m_out;
        e.sel  = m_sel;
        e.busy = (frozen_left > 0 || ramping) ? 1 : 0;
        sb.push_back(e);
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string name, input int act, input int req);
        n_checks = n_checks + 1;
        if (act == req)
            n_pass = n_pass + 1;
        else
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    endtask

    // Monitor: every cycle the DUT presents a new registered sample
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("out", int'(out), e.out);
            check("sel_active", int'(sel_active), e.sel);
            check("busy", int'(busy), e.busy);
        end
    end

    // Stimulus: directed scenarios, then randomized traffic
    initial begin
        for (int k = 0; k < NIN; k++) ins[k] = '0;
        @(negedge clk);
        rst = 1'b1; ticks(2);
        rst = 1'b0;
        // Direct switch
        ins[3] = 14'sd100; ins[5] = -14'sd200; mode = 2'd0;
        sel = 4'd3; ticks(3);
        sel = 4'd5; ticks(3);
        // Hold for four cycles
        sel = 4'd3; ticks(2);
        mode = 2'd1; hold_len = 10'd4; sel = 4'd5; ticks(8);
        // Hold with zero length acts as direct
        hold_len = 10'd0; sel = 4'd3; ticks(2);
        // Ramp 100 -> -200 in steps of 50
        mode = 2'd0; sel = 4'd3; ticks(2);
        mode = 2'd2; step = 13'd50; sel = 4'd5; ticks(9);
        // Ramp with saturation when the target jumps mid-ramp
        mode = 2'd0; ins[0] = 14'sd8000; ins[1] = -14'sd8000; sel = 4'd0; ticks(2);
        mode = 2'd2; step = 13'd1; sel = 4'd1; ticks(3);
        ins[1] = 14'sd8191; ticks(5);
        step = 13'd8191; ticks(4);
        // Select change during a ramp is deferred
        mode = 2'd0; sel = 4'd3; ticks(2);
        mode = 2'd2; step = 13'd50; sel = 4'd5; ticks(2);
        sel = 4'd7; ticks(12);
        // Reset in the middle of a hold
        mode = 2'd0; sel = 4'd3; ticks(2);
        ins[0] = 14'sd33; mode = 2'd1; hold_len = 10'd20; sel = 4'd5; ticks(3);
        rst = 1'b1; ticks(1);
        rst = 1'b0; sel = 4'd0; ticks(3);
        ins[0] = -14'sd77; ticks(2);
        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < NIN; k++)
                if ($urandom_range(0, 3) == 0) ins[k] = RES'($urandom);
            if ($urandom_range(0, 9) == 0) sel = SW'($urandom);
            mode     = 2'($urandom);
            hold_len = HW'($urandom_range(0, 8));
            step     = ($urandom_range(0, 1) == 0) ? 13'($urandom_range(0, 40))
                                                   : 13'($urandom_range(500, 8191));
            rst      = ($urandom_range(0, 399) == 0);
            tick();
        end
        rst = 1'b0;
        @(posedge clk);
        #2;
        check("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/muxer_bumpless.md
Name: muxer_bumpless

Overview:
Registered N:1 signal selector for the lock-in/PID signal routing, replacing fixed 8-input muxers.
- Parametrised input count and width.
- When the select changes, the output transition can be immediate, frozen for a programmable hold time, or bumpless: the offset between the old and new source decays linearly to zero.
- Sits between the signal sources (demodulators, filters, ADC) and the PID/DAC inputs, so re-routing a live loop does not inject steps.

Parameters:
RES, 14, sample width; all data is signed two's complement.
SW, 4, select width; NIN = 2**SW inputs.
HW, 10, hold counter width.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
sel  in  SW  requested input index
in_bus  in  NIN*RES  packed inputs; input k = in_bus[k*RES +: RES]
mode  in  2  0 DIRECT, 1 HOLD, 2 RAMP, 3 reserved (treated as DIRECT)
hold_len  in  HW  HOLD duration in cycles
step  in  RES-1  unsigned ramp decrement per cycle; 0 treated as 1
out  out  RES  registered output sample
sel_active  out  SW  input index currently driving out
busy  out  1  high while in HOLD or RAMP state

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Reset, and rst asserted in any state: out=0, sel_active=0, busy=0, offset=0, cnt=0, state=IDLE.
- States: IDLE, HOLD, RAMP. busy = (state != IDLE), registered.
- IDLE, sel == sel_active: out <= in[sel_active]; 1-cycle latency.
- IDLE, sel != sel_active: this is a switch event. mode is sampled only in this cycle.
  - DIRECT, or HOLD with hold_len=0: sel_active <= sel; out <= in[sel]; stay in IDLE.
  - HOLD: sel_active <= sel; out keeps its value; cnt <= hold_len-1; go to HOLD.
  - RAMP: sel_active <= sel; offset <= out - in[sel], computed at RES+1 bits signed; out keeps its value; go to RAMP.
- HOLD: out frozen.
  - cnt==0: go to IDLE; out tracks from the next cycle.
  - otherwise cnt decrements.
  - Net effect: out is frozen for exactly hold_len cycles after the switch cycle.
- RAMP: off_n = offset moved toward zero by step.
  - If |offset| <= step, off_n = 0.
  - Otherwise off_n = offset - sign(offset)*step.
  - out <= sat(in[sel_active] + off_n); offset <= off_n.
  - When off_n == 0, go to IDLE in the same cycle.
  - RAMP lasts ceil(|offset0|/step) cycles. An offset0 of 0 gives one RAMP cycle.
- sat(): clamp the RES+2-bit sum to [-2**(RES-1), 2**(RES-1)-1].
- Changes to sel during HOLD/RAMP are ignored until IDLE is reached. If sel still differs from sel_active on the first IDLE cycle, that cycle is a new switch event.
- Changes to mode, hold_len and step during HOLD/RAMP do not affect the transition in progress. Exception: step is re-read every RAMP cycle; this is allowed and intended for live tuning.
- Inputs may change freely during RAMP; out follows in + off_n with saturation.

Decomposition:
- Package muxer_pkg holds:
  - MODE_DIRECT/MODE_HOLD/MODE_RAMP constants;
  - the state encoding (IDLE=0, HOLD=1, RAMP=2);
  - function sat_res(value, RES).
- One sub-module, muxer_ramp_step: combinational off_n computation (offset, step -> off_n, done). It is unit-testable on its own.
- The input select is an indexed part-select of in_bus; no sub-module.

Test Plan:
1. DIRECT: in3=100, in5=-200, sel 3->5 -> out=-200 one cycle after sel changes; busy stays 0; sel_active=5.
2. HOLD, hold_len=4: sel 3->5 -> out=100 for the switch cycle plus 4 cycles, then -200; busy high exactly 4 cycles.
3. RAMP, step=50, in3=100 -> in5=-200: out = 100, 50, 0, -50, -100, -150, -200, then tracks in5; busy high 6 cycles.
4. RAMP saturation, RES=14: in0=8000, in1=-8000, step=1, sel 0->1, then drive in1=8191 mid-ramp -> out clamps at 8191, no wrap.
5. sel 3->5 (RAMP), then sel=7 during the ramp -> sel_active stays 5 until busy falls; the next cycle starts a new 5->7 switch.
6. rst asserted mid-HOLD with out=100 -> next cycle out=0, busy=0, sel_active=0; after rst release with sel=0, out tracks in0.
